ddr_line_prefetch: RTL and testbench
====================================

Name: ddr_line_prefetch

Overview:
- Sits directly downstream of the DDR controller and upstream of the VGA pixel pipeline.
- Issues sequential read requests for one scanline, starting at a line base address, and buffers the returned 32-bit words in a FIFO.
- Serves 16-bit pixels to the display side on demand.
- All logic runs in the 133 MHz DDR command clock domain.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 32-bit words (16).
- BURST_WORDS, 2: 32-bit words returned per read request.
- LINE_WORDS, 320: words per scanline (640 pixels x 16 bit).
- ADDR_W, 24: linear word-address width.

Ports:
- clk133_p  in  1  single clock; all logic samples on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- lineStart  in  1  one-cycle pulse that begins prefetch of a new line.
- lineBase  in  ADDR_W  first word address of the line; sampled when lineStart=1.
- rdReq  out  1  read request to the DDR controller; held high until acknowledged.
- rdAddr  out  ADDR_W  word address of the requested burst; stable while rdReq=1.
- rdAck  in  1  controller has accepted the request (one cycle).
- rdValid  in  1  rdData carries one returned word this cycle.
- rdData  in  32  returned read data.
- pixRd  in  1  pop one pixel.
- pixData  out  16  head pixel; valid when pixEmpty=0.
- pixEmpty  out  1  no pixel available.
- lineDone  out  1  every word of the current line has been received.
- underflow  out  1  sticky: pixRd was asserted while pixEmpty=1.
- overflow  out  1  sticky: rdValid arrived while the FIFO was full.

Behaviour:
- Reset values (rst=0, asynchronous): rdReq=0, rdAddr=0, pixData=0, pixEmpty=1, lineDone=1, underflow=0, overflow=0. FIFO is empty, FSM is in IDLE, half-select points to the low half.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE: lineDone=1. On lineStart, flush the FIFO, load addr=lineBase and wordCnt=0, then go to REQ.
- REQ: assert rdReq only when (FIFO free slots) >= BURST_WORDS. On rdAck, drop rdReq the next cycle, set rxCnt=0, go to WAIT.
- WAIT: each rdValid pushes rdData and increments rxCnt. When rxCnt reaches BURST_WORDS:
  - addr += BURST_WORDS, wrapping modulo 2^ADDR_W;
  - wordCnt += BURST_WORDS;
  - if wordCnt = LINE_WORDS go to IDLE, otherwise go to REQ.
- Outstanding requests: at most one at a time. The free-space check covers the whole burst, so overflow cannot occur when the controller is compliant.
- lineStart while in REQ with rdAck not yet seen: drop rdReq, flush, load the new base, return to REQ.
- lineStart while in WAIT: go to DRAIN. DRAIN discards the remaining (BURST_WORDS - rxCnt) words without pushing them, then flushes, loads the new base, and goes to REQ. The new base is latched at the lineStart cycle.
- lineStart and rdAck in the same cycle: the ack wins. Treat the burst as in flight and go to DRAIN.
- Pixel side:
  - pixData = low half of the head word when half=0, high half when half=1.
  - pixRd with pixEmpty=0 toggles half; the second pop (half=1) pops the word.
  - pixEmpty = (count==0).
  - Output is combinational from the FIFO head, so a pushed word is visible the cycle after rdValid.
- Push and word-pop in the same cycle: both take effect and count is unchanged. This is legal even when the FIFO is full.
- pixRd while empty: ignored; set underflow.
- rdValid while full: drop the word; set overflow.
- Both sticky flags clear only on reset or lineStart.
- A flush clears count, read and write pointers, and half. It does not touch wordCnt except through the base reload.
- lineDone deasserts the cycle after lineStart and reasserts when the FSM returns to IDLE. The FIFO may still hold pixels at that point.

Test Plan:
- Reset then idle: rst low for 3 cycles, released -> rdReq=0, pixEmpty=1, lineDone=1, no requests without lineStart.
- Full line: lineStart with lineBase=0x000100; controller acks after 2 cycles and returns 0xAAAA5555 patterns; pixRd held high -> 160 requests with rdAddr 0x000100, 0x000102, ..., 0x00023E. Result: 640 pixels in order, low half first; lineDone rises after word 320; underflow=0.
- Backpressure: pixRd=0 throughout -> exactly 8 requests (16 words), pixEmpty=0, overflow=0. A single pixRd pair (one word pop) is not enough to issue a request; the request issues only after 2 words are popped.
- Abort mid-burst: lineStart with lineBase=0x001000 after the first of two rdValid words -> second word discarded, FIFO empty, next rdAddr=0x001000.
- Underflow and overflow: pixRd while empty -> underflow=1 and sticky. A forced rdValid while the FIFO is full -> overflow=1 and FIFO contents unchanged. lineStart clears both flags.
- Address wrap and reset mid-operation: lineBase=0xFFFFFE -> second rdAddr is 0x000000. rst asserted while in WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ddr_line_prefetch.sv
// ddr_line_prefetch: bursts one scanline of DDR reads into a word FIFO and serves 16-bit pixels on demand
module ddr_line_prefetch #(
  parameter int DEPTH_LOG2  = 4,
  parameter int BURST_WORDS = 2,
  parameter int LINE_WORDS  = 320,
  parameter int ADDR_W      = 24
) (
  input  logic              clk133_p,
  input  logic              rst,
  input  logic              lineStart,
  input  logic [ADDR_W-1:0] lineBase,
  output logic              rdReq,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic              rdAck,
  input  logic              rdValid,
  input  logic [31:0]       rdData,
  input  logic              pixRd,
  output logic [15:0]       pixData,
  output logic              pixEmpty,
  output logic              lineDone,
  output logic              underflow,
  output logic              overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int WCW   = $clog2(LINE_WORDS + BURST_WORDS + 1);
  localparam int RCW   = $clog2(BURST_WORDS + 2);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [RCW-1:0]        rx_cnt_q, rx_cnt_d, rx_inc;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  half_q, half_d, underflow_q, underflow_d, overflow_q, overflow_d;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           head;
  logic                  empty, full, ack, pop, word_pop, push, flush;
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(DEPTH);
  assign rdReq     = state_q == REQ && count_q <= CW'(DEPTH - BURST_WORDS);
  assign ack       = rdReq && rdAck;
  assign pop       = pixRd && !empty;
  assign word_pop  = pop && half_q;
  assign push      = state_q == WAIT && rdValid && (!full || word_pop);
  assign rx_inc    = rx_cnt_q + RCW'(rdValid);
  assign head      = mem_q[rd_ptr_q];
  assign pixData   = empty ? '0 : (half_q ? head[31:16] : head[15:0]);
  assign pixEmpty  = empty;
  assign lineDone  = state_q == IDLE;
  assign rdAddr    = addr_q;
  assign underflow = underflow_q;
  assign overflow  = overflow_q;
  // Request sequencing: one burst in flight, aborts drain the remainder before restarting
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    flush      = 1'b0;
    case (state_q)
      IDLE: if (lineStart) begin
        state_d = REQ;
        flush   = 1'b1;
      end
      REQ: if (ack) begin
        state_d  = lineStart ? DRAIN : WAIT;
        rx_cnt_d = '0;
      end else if (lineStart) flush = 1'b1;
      WAIT: begin
        if (rdValid) rx_cnt_d = rx_inc;
        if (lineStart) state_d = DRAIN;
        else if (rdValid && rx_inc == RCW'(BURST_WORDS)) begin
          addr_d     = addr_q + ADDR_W'(BURST_WORDS);
          word_cnt_d = word_cnt_q + WCW'(BURST_WORDS);
          state_d    = word_cnt_d == WCW'(LINE_WORDS) ? IDLE : REQ;
        end
      end
      default: if (rx_inc >= RCW'(BURST_WORDS)) begin
        state_d = REQ;
        flush   = 1'b1;
      end else rx_cnt_d = rx_inc;
    endcase
    if (lineStart) begin
      addr_d     = lineBase;
      word_cnt_d = '0;
    end
  end
  // FIFO pointers, pixel half-select and sticky error flags
  always_comb begin
    underflow_d = lineStart ? 1'b0 : underflow_q | (pixRd && empty);
    overflow_d  = lineStart ? 1'b0 : overflow_q | (rdValid && full && !word_pop);
    wr_ptr_d    = flush ? '0 : wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d    = flush ? '0 : rd_ptr_q + DEPTH_LOG2'(word_pop);
    count_d     = flush ? '0 : count_q + CW'(push) - CW'(word_pop);
    half_d      = flush ? 1'b0 : half_q ^ pop;
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      rx_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      half_q      <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      half_q      <= half_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end
  // FIFO storage, contents need no reset since count gates visibility
  always_ff @(posedge clk133_p) begin
    if (push) mem_q[wr_ptr_q] <= rdData;
  end
endmodule

// File: tb/tb_ddr_line_prefetch.sv
// tb_ddr_line_prefetch: directed self-checking bench for the scanline prefetcher
module tb_ddr_line_prefetch;
  logic        clk = 1'b0;
  logic        rst, lineStart, rdAck, rdValid, pixRd;
  logic [23:0] lineBase;
  logic [31:0] rdData;
  logic        rdReq, pixEmpty, lineDone, underflow, overflow;
  logic [23:0] rdAddr;
  logic [15:0] pixData;
  int          checks = 0, errors = 0;
  int          phase, wait_c, sent, wcount, reqs;
  logic [23:0] exp_addr;

  always #5 clk = ~clk;

  ddr_line_prefetch dut (
    .clk133_p(clk), .rst(rst), .lineStart(lineStart), .lineBase(lineBase),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdAck(rdAck), .rdValid(rdValid), .rdData(rdData),
    .pixRd(pixRd), .pixData(pixData), .pixEmpty(pixEmpty), .lineDone(lineDone),
    .underflow(underflow), .overflow(overflow)
  );

  function automatic logic [31:0] wdat(input int k);
    wdat = {16'hAAAA ^ k[15:0], 16'h5555 ^ k[15:0]};
  endfunction

  function automatic logic [15:0] pix(input int i);
    logic [31:0] w;
    w = wdat(i / 2);
    pix = (i % 2) ? w[31:16] : w[15:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_reset(input logic [23:0] a);
    phase = 0; wait_c = 0; sent = 0; wcount = 0; reqs = 0; exp_addr = a;
  endtask

  task automatic start_line(input logic [23:0] a);
    lineStart = 1'b1; lineBase = a;
    tick;
    lineStart = 1'b0;
  endtask

  // Compliant controller: acks after two cycles of rdReq, then returns two words
  task automatic ctl_cycle;
    rdAck = 1'b0; rdValid = 1'b0;
    if (phase == 1) begin
      rdValid = 1'b1; rdData = wdat(wcount); wcount++; sent++;
      if (sent == 2) begin sent = 0; phase = 0; end
    end else if (rdReq) begin
      wait_c++;
      if (wait_c >= 2) begin
        checks++;
        if (rdAddr !== exp_addr) begin errors++; $display("FAIL req_addr #%0d: got %h expected %h", reqs, rdAddr, exp_addr); end
        rdAck = 1'b1; exp_addr += 24'd2; reqs++; wait_c = 0; phase = 1;
      end
    end
  endtask

  task automatic test_reset;
    logic bad;
    rst = 1'b0; lineStart = 1'b0; lineBase = '0; rdAck = 1'b0; rdValid = 1'b0; rdData = '0; pixRd = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    checks++; if (rdReq !== 1'b0) begin errors++; $display("FAIL reset_rdReq: got %b expected 0", rdReq); end
    checks++; if (rdAddr !== 24'h0) begin errors++; $display("FAIL reset_rdAddr: got %h expected 000000", rdAddr); end
    checks++; if (pixEmpty !== 1'b1 || pixData !== 16'h0) begin errors++; $display("FAIL reset_pix: got empty=%b data=%h expected 1/0000", pixEmpty, pixData); end
    checks++; if (lineDone !== 1'b1) begin errors++; $display("FAIL reset_lineDone: got %b expected 1", lineDone); end
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", underflow, overflow); end
    bad = 1'b0;
    repeat (20) begin tick; if (rdReq !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL idle_no_req: got request expected none"); end
  endtask

  task automatic test_full_line;
    int pix_i;
    logic ld_bad, ld_seen;
    ctl_reset(24'h000100);
    start_line(24'h000100);
    pix_i = 0; ld_bad = 1'b0; ld_seen = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (wcount == 320 && phase == 0 && !ld_seen) begin
        ld_seen = 1'b1;
        checks++; if (lineDone !== 1'b1) begin errors++; $display("FAIL line_done_rise: got %b expected 1", lineDone); end
      end else if (!ld_seen && lineDone !== 1'b0) ld_bad = 1'b1;
      if (!pixEmpty) begin
        checks++; if (pixData !== pix(pix_i)) begin errors++; $display("FAIL pixel #%0d: got %h expected %h", pix_i, pixData, pix(pix_i)); end
        pix_i++; pixRd = 1'b1;
      end else pixRd = 1'b0;
      ctl_cycle;
      tick;
      if (pix_i == 640 && wcount == 320 && phase == 0) break;
    end
    pixRd = 1'b0; rdAck = 1'b0; rdValid = 1'b0;
    checks++; if (pix_i !== 640) begin errors++; $display("FAIL line_pixels: got %0d expected 640", pix_i); end
    checks++; if (reqs !== 160) begin errors++; $display("FAIL line_requests: got %0d expected 160", reqs); end
    checks++; if (!ld_seen || ld_bad) begin errors++; $display("FAIL line_done_low: got seen=%b early=%b expected 1/0", ld_seen, ld_bad); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL line_underflow: got %b expected 0", underflow); end
    checks++; if (lineDone !== 1'b1 || rdReq !== 1'b0) begin errors++; $display("FAIL line_idle: got done=%b req=%b expected 1/0", lineDone, rdReq); end
  endtask

  task automatic test_backpressure;
    ctl_reset(24'h000200);
    pixRd = 1'b0;
    start_line(24'h000200);
    repeat (100) begin ctl_cycle; tick; end
    checks++; if (reqs !== 8) begin errors++; $display("FAIL bp_requests: got %0d expected 8", reqs); end
    checks++; if (pixEmpty !== 1'b0 || pixData !== 16'h5555) begin errors++; $display("FAIL bp_head: got empty=%b data=%h expected 0/5555", pixEmpty, pixData); end
    checks++; if (overflow !== 1'b0 || rdReq !== 1'b0) begin errors++; $display("FAIL bp_full: got ovf=%b req=%b expected 0/0", overflow, rdReq); end
    pixRd = 1'b1;
    tick;
    checks++; if (pixData !== 16'hAAAA) begin errors++; $display("FAIL bp_high_half: got %h expected aaaa", pixData); end
    tick;
    pixRd = 1'b0;
    repeat (10) begin ctl_cycle; tick; end
    checks++; if (reqs !== 8 || rdReq !== 1'b0) begin errors++; $display("FAIL bp_one_pop: got reqs=%0d req=%b expected 8/0", reqs, rdReq); end
    checks++; if (pixData !== 16'h5554) begin errors++; $display("FAIL bp_word1: got %h expected 5554", pixData); end
    pixRd = 1'b1;
    tick; tick;
    pixRd = 1'b0;
    checks++; if (rdReq !== 1'b1 || rdAddr !== 24'h000210) begin errors++; $display("FAIL bp_two_pops: got req=%b addr=%h expected 1/000210", rdReq, rdAddr); end
  endtask

  task automatic test_abort;
    start_line(24'h000300);
    checks++; if (pixEmpty !== 1'b1 || rdReq !== 1'b1 || rdAddr !== 24'h000300) begin errors++; $display("FAIL req_restart: got empty=%b req=%b addr=%h expected 1/1/000300", pixEmpty, rdReq, rdAddr); end
    rdAck = 1'b1;
    tick;
    rdAck = 1'b0; rdValid = 1'b1; rdData = 32'h1111_2222;
    tick;
    rdValid = 1'b0;
    checks++; if (pixEmpty !== 1'b0 || pixData !== 16'h2222) begin errors++; $display("FAIL abort_first_word: got empty=%b data=%h expected 0/2222", pixEmpty, pixData); end
    start_line(24'h001000);
    checks++; if (rdReq !== 1'b0 || lineDone !== 1'b0) begin errors++; $display("FAIL abort_drain: got req=%b done=%b expected 0/0", rdReq, lineDone); end
    rdValid = 1'b1; rdData = 32'h3333_4444;
    tick;
    rdValid = 1'b0;
    checks++; if (pixEmpty !== 1'b1 || rdReq !== 1'b1 || rdAddr !== 24'h001000) begin errors++; $display("FAIL abort_restart: got empty=%b req=%b addr=%h expected 1/1/001000", pixEmpty, rdReq, rdAddr); end
  endtask

  task automatic test_flags;
    int i;
    pixRd = 1'b1;
    tick;
    pixRd = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", underflow); end
    tick; tick;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b expected 1", underflow); end
    ctl_reset(24'h002000);
    start_line(24'h002000);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b expected 0", underflow); end
    repeat (100) begin ctl_cycle; tick; end
    rdAck = 1'b0;
    checks++; if (reqs !== 8) begin errors++; $display("FAIL ovf_fill: got %0d expected 8", reqs); end
    rdValid = 1'b1; rdData = 32'hDEAD_BEEF;
    tick;
    rdValid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    i = 0;
    for (int c = 0; c < 40; c++) begin
      if (!pixEmpty) begin
        checks++; if (pixData !== pix(i)) begin errors++; $display("FAIL ovf_contents #%0d: got %h expected %h", i, pixData, pix(i)); end
        i++; pixRd = 1'b1;
      end else pixRd = 1'b0;
      tick;
    end
    pixRd = 1'b0;
    checks++; if (i !== 32) begin errors++; $display("FAIL ovf_count: got %0d pixels expected 32", i); end
    checks++; if (overflow !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL overflow_sticky: got ovf=%b unf=%b expected 1/0", overflow, underflow); end
  endtask

  task automatic test_wrap_reset;
    ctl_reset(24'hFFFFFE);
    start_line(24'hFFFFFE);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
    for (int c = 0; c < 200; c++) begin
      ctl_cycle;
      tick;
      if (reqs == 3) break;
    end
    rdAck = 1'b0; rdValid = 1'b0;
    checks++; if (reqs !== 3 || exp_addr !== 24'h000004) begin errors++; $display("FAIL wrap_reqs: got %0d next=%h expected 3/000004", reqs, exp_addr); end
    checks++; if (pixEmpty !== 1'b0 || rdReq !== 1'b0 || lineDone !== 1'b0) begin errors++; $display("FAIL wait_state: got empty=%b req=%b done=%b expected 0/0/0", pixEmpty, rdReq, lineDone); end
    rst = 1'b0;
    #1;
    checks++; if (rdReq !== 1'b0 || rdAddr !== 24'h0 || pixData !== 16'h0) begin errors++; $display("FAIL async_reset_rd: got req=%b addr=%h data=%h expected 0/000000/0000", rdReq, rdAddr, pixData); end
    checks++; if (pixEmpty !== 1'b1 || lineDone !== 1'b1 || underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL async_reset_state: got empty=%b done=%b flags=%b%b expected 1/1/00", pixEmpty, lineDone, underflow, overflow); end
    tick;
    rst = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_full_line;
    test_backpressure;
    test_abort;
    test_flags;
    test_wrap_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
